// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM sequencing fetch/decode/execute
// for lw, sw, R-type, beq, j and addi, with a sticky illegal-opcode flag.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read instruction into IR, PC <= PC + 4
// DECODE | read registers, precompute branch target
// MEMADR | compute load/store address (base + imm)
// MEMRD  | read data memory at computed address
// MEMWB  | write loaded word to rt
// MEMWR  | write rt to data memory
// EXEC   | R-type ALU operation
// RWB    | write ALU result to rd
// BEQ    | compare, load branch target into PC when Zero
// JUMP   | load jump target into PC
// ADDIEX | addi ALU operation (rs + imm)
// ADDIWB | write addi result to rt

module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
    output logic               PC_En,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [STATE_W-1:0] State,
    output logic               Illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcen;
    } ctrl_t;

    state_t state;
    state_t nxt_state;
    ctrl_t  ctrl;
    logic   illegal_q;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread  = 1'b1;
                c.irwrite  = 1'b1;
                c.alusrcb  = 2'b01;
                c.pcen     = 1'b1;
            end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                c.alusrca  = 1'b1;
                c.alusrcb  = 2'b10;
            end
            S_MEMRD: begin
                c.memread  = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca  = 1'b1;
                c.aluop    = 2'b10;
            end
            S_RWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BEQ: begin
                c.alusrca  = 1'b1;
                c.aluop    = 2'b01;
                c.pcsource = 2'b01;
            end
            S_JUMP: begin
                c.pcsource = 2'b10;
                c.pcen     = 1'b1;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Opcode only matters in DECODE and MEMADR; anything but sw in MEMADR is treated as lw.
    always_comb begin
        nxt_state = S_FETCH;
        case (state)
            S_FETCH: nxt_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_J:         nxt_state = S_JUMP;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: nxt_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt_state = S_MEMWB;
            S_EXEC:   nxt_state = S_RWB;
            S_ADDIEX: nxt_state = S_ADDIWB;
            default:  nxt_state = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they always track the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ctrl      <= decode(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            state <= nxt_state;
            ctrl  <= decode(nxt_state);
            if (state == S_DECODE && nxt_state == S_FETCH)
                illegal_q <= 1'b1;
        end
    end

    assign PC_En    = ctrl.pcen | ((state == S_BEQ) & Zero);
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.memread;
    assign MemWrite = ctrl.memwrite;
    assign IRWrite  = ctrl.irwrite;
    assign MemToReg = ctrl.memtoreg;
    assign RegDst   = ctrl.regdst;
    assign RegWrite = ctrl.regwrite;
    assign ALUSrcA  = ctrl.alusrca;
    assign ALUSrcB  = ctrl.alusrcb;
    assign ALUOp    = ctrl.aluop;
    assign PCSource = ctrl.pcsource;
    assign State    = STATE_W'(state);
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction scenarios plus a random
// instruction stream, checked cycle by cycle against per-instruction state paths.

module tb_multicycle_control;

    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PC_En, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic       Illegal;

    int  checks = 0;
    int  errors = 0;
    int  ncyc   = 0;
    logic exp_illegal = 1'b0;

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero),
        .PC_En(PC_En), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .State(State), .Illegal(Illegal)
    );

    // {IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [13:0] exp_ctrl(input int s);
        case (s)
            0:       return 14'b0_1_0_1_0_0_0_0_01_00_00;
            1:       return 14'b0_0_0_0_0_0_0_0_11_00_00;
            2, 10:   return 14'b0_0_0_0_0_0_0_1_10_00_00;
            3:       return 14'b1_1_0_0_0_0_0_0_00_00_00;
            4:       return 14'b0_0_0_0_1_0_1_0_00_00_00;
            5:       return 14'b1_0_1_0_0_0_0_0_00_00_00;
            6:       return 14'b0_0_0_0_0_0_0_1_00_10_00;
            7:       return 14'b0_0_0_0_0_1_1_0_00_00_00;
            8:       return 14'b0_0_0_0_0_0_0_1_00_01_01;
            9:       return 14'b0_0_0_0_0_0_0_0_00_00_10;
            11:      return 14'b0_0_0_0_0_0_1_0_00_00_00;
            default: return 14'b0;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [5:0] op);
        return !(op == LW || op == SW || op == RTYPE || op == BEQ || op == JMP || op == ADDI);
    endfunction

    // Entered and left at a falling edge; drives inputs, then checks the current cycle.
    task automatic cycle(input int s, input logic [5:0] op, input logic z);
        logic [13:0] got;
        logic        exp_pc;
        Opcode = op;
        Zero   = z;
        #1;
        got    = {IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource};
        exp_pc = (s == 0) || (s == 9) || (s == 8 && z);
        checks++;
        assert (State === 4'(s)) else begin
            errors++; $error("FAIL state: got %0d expected %0d (cycle %0d)", State, s, ncyc);
        end
        checks++;
        assert (got === exp_ctrl(s)) else begin
            errors++; $error("FAIL ctrl s%0d: got %b expected %b", s, got, exp_ctrl(s));
        end
        checks++;
        assert (PC_En === exp_pc) else begin
            errors++; $error("FAIL pc_en s%0d zero=%b: got %b expected %b", s, z, PC_En, exp_pc);
        end
        checks++;
        assert (Illegal === exp_illegal) else begin
            errors++; $error("FAIL illegal s%0d: got %b expected %b", s, Illegal, exp_illegal);
        end
        checks++;
        assert (!(MemRead && MemWrite) && !(RegWrite && MemWrite) && State <= 4'd11) else begin
            errors++; $error("FAIL invariant: MemRead=%b MemWrite=%b RegWrite=%b State=%0d expected no overlap, State<=11",
                             MemRead, MemWrite, RegWrite, State);
        end
        ncyc++;
        @(negedge clk);
    endtask

    // zmode: 0/1 fixed Zero, 2 random Zero. rnd: garbage Opcode outside DECODE/MEMADR.
    task automatic run_instr(input logic [5:0] op, input bit rnd, input int zmode);
        int       path[$];
        logic [5:0] drv;
        logic     z;
        case (op)
            LW:      path = '{0, 1, 2, 3, 4};
            SW:      path = '{0, 1, 2, 5};
            RTYPE:   path = '{0, 1, 6, 7};
            BEQ:     path = '{0, 1, 8};
            JMP:     path = '{0, 1, 9};
            ADDI:    path = '{0, 1, 10, 11};
            default: path = '{0, 1};
        endcase
        foreach (path[i]) begin
            drv = (path[i] == 1 || path[i] == 2 || !rnd) ? op : 6'($urandom);
            z   = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            cycle(path[i], drv, z);
            if (path[i] == 1 && is_illegal(op))
                exp_illegal = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_illegal = 1'b0;
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        ops = '{LW, SW, RTYPE, BEQ, JMP, ADDI};
        rst = 1'b1;
        Opcode = '0;
        Zero = 1'b0;
        @(negedge clk);
        do_reset();

        run_instr(LW,    1'b0, 0);
        run_instr(SW,    1'b1, 2);
        run_instr(BEQ,   1'b0, 1);
        run_instr(BEQ,   1'b0, 0);
        run_instr(RTYPE, 1'b1, 2);
        run_instr(JMP,   1'b1, 2);
        run_instr(ADDI,  1'b1, 2);
        run_instr(6'b111111, 1'b0, 0);
        run_instr(LW,    1'b1, 2);

        // Reset in the middle of a load, with Illegal already set.
        cycle(0, LW, 1'b0);
        cycle(1, LW, 1'b0);
        cycle(2, LW, 1'b0);
        rst = 1'b1;
        cycle(3, LW, 1'b0);
        rst = 1'b0;
        exp_illegal = 1'b0;
        run_instr(LW, 1'b0, 0);
        run_instr(SW, 1'b0, 0);

        while (ncyc < 10000) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, 1'b1, 2);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        do_reset();
        cycle(0, 6'($urandom), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter STATE_W, default 4, giving the state register width (fixed to 4 for this design).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port Zero  input  1  ALU zero flag (combinational, same cycle).
REQ-006 The block SHALL have port PC_En  output  1  PC load enable.
REQ-007 The block SHALL have outputs IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, each 1 bit, as standard multicycle datapath selects/enables.
REQ-008 The block SHALL have outputs ALUSrcB, ALUOp, PCSource, each 2 bits.
REQ-009 The block SHALL have port State  output  STATE_W  current state encoding, for debug.
REQ-010 The block SHALL have port Illegal  output  1  sticky flag for an unsupported opcode seen in DECODE.

Function
REQ-011 The block SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (lw 100011, sw 101011), EXEC (000000), BEQ (000100), JUMP (000010), ADDIEX (001000), FETCH (any other opcode).
REQ-013 Further transitions SHALL be: MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->RWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RWB, BEQ, JUMP, ADDIWB->FETCH.
REQ-014 State encodings 12-15 SHALL transition to FETCH next cycle and drive all outputs 0.
REQ-015 Every output except PC_En SHALL be a pure function of the state register; any output not listed for a state SHALL be 0.
REQ-016 FETCH SHALL drive MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PC_En=1.
REQ-017 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-018 MEMADR and ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-019 MEMRD SHALL drive MemRead=1, IorD=1; MEMWR SHALL drive MemWrite=1, IorD=1.
REQ-020 MEMWB SHALL drive RegDst=0, MemToReg=1, RegWrite=1; ADDIWB SHALL drive RegDst=0, MemToReg=0, RegWrite=1.
REQ-021 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; RWB SHALL drive RegDst=1, MemToReg=0, RegWrite=1.
REQ-022 BEQ SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PC_En=Zero (combinational from Zero).
REQ-023 JUMP SHALL drive PCSource=10, PC_En=1.
REQ-024 Instruction latency in cycles from FETCH SHALL be: lw 5; R-type, sw and addi 4; beq and j 3; illegal 2.
REQ-025 Illegal SHALL be set to 1 on the clock edge leaving DECODE to FETCH because of an unsupported opcode, SHALL stay 1, and SHALL be cleared only by reset.
REQ-026 Opcode SHALL be sampled only in DECODE and MEMADR; its value in all other states SHALL have no effect.
REQ-027 MemRead and MemWrite SHALL never be 1 in the same cycle, and RegWrite and MemWrite SHALL never be 1 in the same cycle.

Reset
REQ-028 When rst=1 at a rising clk edge, the block SHALL set State to FETCH and Illegal to 0, regardless of the current state, including mid-instruction.
REQ-029 In the first cycle after reset, outputs SHALL equal the FETCH values: PC_En=1, MemRead=1, IRWrite=1, ALUSrcB=01, all other outputs 0.
REQ-030 rst SHALL take priority over every transition and over the Illegal set condition in the same cycle.

Verification
REQ-031 Scenario lw: rst, then Opcode=100011 -> State 0,1,2,3,4,0; MemToReg=1 and RegWrite=1 only in state 4; IorD=1 in state 3.
REQ-032 Scenario beq: Opcode=000100 with Zero=1 in state 8 -> PC_En=1 and PCSource=01; repeat with Zero=0 -> PC_En=0; both return to 0 after 3 cycles.
REQ-033 Scenario R-type, j and addi: Opcode=000000 -> 0,1,6,7,0 with RegDst=1 in 7; Opcode=000010 -> 0,1,9,0 with PCSource=10; Opcode=001000 -> 0,1,10,11,0.
REQ-034 Scenario illegal: Opcode=111111 -> 0,1,0 and Illegal=1 from the following cycle; it stays 1 through a later lw and clears only after rst.
REQ-035 Scenario reset mid-op: assert rst while in state 3 (lw) -> next state 0, Illegal=0, and no MemWrite or RegWrite pulse occurs.
REQ-036 Scenario invariants: random opcodes for 10k cycles -> REQ-027 never violated and State never exceeds 11.
